// File: rtl/mips_decode_stage.sv
// -----------------------------------------------------------------------------
// mips_decode_stage
//
// Registered MIPS-I instruction decode stage. It sits between fetch and the
// register-file/ALU stage. Each instruction word is split into its fields,
// classified as R/I/J, and given an extended immediate and a jump target.
// Decoding happens as the word enters a register, so the outputs come
// straight from flops.
//
// Flow control is a valid/ready handshake with a 2-entry buffer: an output
// register plus one skid register. in_ready depends only on a flop
// (~skid_valid), so no combinational path runs from out_ready to in_ready.
// Order is strictly FIFO. flush empties both entries.
//
// Optional feature (macro MIPS_DECODE_ILLEGAL_EN):
//   defined   - illegal flags unsupported opcodes and, for op=0, unsupported
//               func codes. It travels with the word through both registers.
//   undefined - illegal is constant 0 and no check logic is built.
//
// Parameters
//   DATA_W   width of imm_ext (must be >= 16)
//   COUNT_W  width of dec_count
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   flush      in   discard every buffered instruction
//   in_valid   in   Inst_code is valid
//   in_ready   out  stage can accept a word this cycle
//   Inst_code  in   32-bit instruction word
//   out_valid  out  decoded fields are valid
//   out_ready  in   downstream accepts this cycle
//   op_code    out  Inst_code[31:26]
//   rs_addr    out  Inst_code[25:21]
//   rt_addr    out  Inst_code[20:16]
//   rd_addr    out  Inst_code[15:11]
//   shamt      out  Inst_code[10:6]
//   func       out  Inst_code[5:0]
//   imm_ext    out  Inst_code[15:0]; zero-extended for andi/ori/xori,
//                   sign-extended otherwise
//   jaddr      out  Inst_code[25:0]
//   inst_type  out  0=R, 1=I, 2=J
//   illegal    out  unsupported opcode/func (only with the macro defined)
//   dec_count  out  saturating count of output handshakes since reset
// -----------------------------------------------------------------------------
module mips_decode_stage #(
  parameter int DATA_W  = 32,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        Inst_code,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [5:0]         op_code,
  output logic [4:0]         rs_addr,
  output logic [4:0]         rt_addr,
  output logic [4:0]         rd_addr,
  output logic [4:0]         shamt,
  output logic [5:0]         func,
  output logic [DATA_W-1:0]  imm_ext,
  output logic [25:0]        jaddr,
  output logic [1:0]         inst_type,
  output logic               illegal,
  output logic [COUNT_W-1:0] dec_count
);

  typedef enum logic [1:0] {
    TYPE_R = 2'd0,
    TYPE_I = 2'd1,
    TYPE_J = 2'd2
  } inst_type_e;

  // One decoded instruction. The output register and the skid register
  // both hold this record.
  typedef struct packed {
    logic [5:0]        op;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        sh;
    logic [5:0]        fn;
    logic [DATA_W-1:0] imm;
    logic [25:0]       ja;
    inst_type_e        itype;
    logic              ill;
  } dec_t;

  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  function automatic dec_t decode(input logic [31:0] w);
    dec_t d;
`ifdef MIPS_DECODE_ILLEGAL_EN
    logic op_ok;
    logic fn_ok;
`endif
    d.op = w[31:26];
    d.rs = w[25:21];
    d.rt = w[20:16];
    d.rd = w[15:11];
    d.sh = w[10:6];
    d.fn = w[5:0];
    d.ja = w[25:0];

    // The logical immediates (andi/ori/xori) zero-extend. Every other
    // immediate sign-extends. The size cast of a signed value carries bit 15
    // up, and it stays legal when DATA_W is exactly 16.
    if (w[31:26] == 6'h0C || w[31:26] == 6'h0D || w[31:26] == 6'h0E)
      d.imm = DATA_W'(w[15:0]);
    else
      d.imm = DATA_W'(signed'(w[15:0]));

    if (w[31:26] == 6'h00)
      d.itype = TYPE_R;
    else if (w[31:26] == 6'h02 || w[31:26] == 6'h03)
      d.itype = TYPE_J;
    else
      d.itype = TYPE_I;

`ifdef MIPS_DECODE_ILLEGAL_EN
    case (w[31:26])
      6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
      6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B: op_ok = 1'b1;
      default:                                         op_ok = 1'b0;
    endcase
    case (w[5:0])
      6'h00, 6'h02, 6'h03, 6'h08, 6'h20, 6'h21, 6'h22,
      6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: fn_ok = 1'b1;
      default:                                         fn_ok = 1'b0;
    endcase
    d.ill = ~op_ok | ((w[31:26] == 6'h00) & ~fn_ok);
`else
    d.ill = 1'b0;
`endif
    return d;
  endfunction

  dec_t               out_q;
  dec_t               skid_q;
  dec_t               in_dec;
  logic               skid_valid;
  logic               accept;
  logic               handshake;
  logic               out_free;
  logic               skid_load;
  logic [COUNT_W-1:0] count_q;

  assign in_dec    = decode(Inst_code);
  assign in_ready  = ~skid_valid;
  assign accept    = in_valid & in_ready;
  assign handshake = out_valid & out_ready;
  // The output register can take a new entry when it is empty or its
  // current entry leaves this cycle.
  assign out_free  = ~out_valid | handshake;
  // A word that arrives while the output register is stalled goes into the
  // skid register. in_ready guarantees the skid register is empty then.
  assign skid_load = accept & ~out_free & ~flush;

  // NOTE: sequential state uses non-blocking assignments only. Every flop
  // then samples the values from before the edge, whatever the statement
  // order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_q      <= '0;
      count_q    <= '0;
    end else begin
      // The counter tracks real handshakes only. flush does not change it.
      if (handshake && count_q != COUNT_MAX)
        count_q <= count_q + COUNT_W'(1);

      if (flush) begin
        // Reset is checked first, so it wins over flush. Any word accepted
        // in this cycle is dropped.
        out_valid  <= 1'b0;
        skid_valid <= 1'b0;
      end else if (out_free) begin
        if (skid_valid) begin
          // The older word in the skid register goes out first. in_ready
          // was low, so no new word arrived in this cycle.
          out_q      <= skid_q;
          out_valid  <= 1'b1;
          skid_valid <= 1'b0;
        end else if (accept) begin
          out_q     <= in_dec;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (skid_load) begin
        skid_valid <= 1'b1;
      end
    end
  end

  // NOTE: the skid payload has no reset. skid_valid qualifies it, so its
  // contents are never visible until it has been loaded, and leaving out the
  // reset keeps these flops simple.
  always_ff @(posedge clk) begin
    if (skid_load)
      skid_q <= in_dec;
  end

  assign op_code   = out_q.op;
  assign rs_addr   = out_q.rs;
  assign rt_addr   = out_q.rt;
  assign rd_addr   = out_q.rd;
  assign shamt     = out_q.sh;
  assign func      = out_q.fn;
  assign imm_ext   = out_q.imm;
  assign jaddr     = out_q.ja;
  assign inst_type = out_q.itype;
  assign illegal   = out_q.ill;
  assign dec_count = count_q;

endmodule
